// File: rtl/mmio_pkg.sv
// mmio_pkg: shared types and defaults for the MMIO data-side bus controller.
//   mmio_state_t  : controller FSM states
//   *_DEF         : default memory-map / peripheral geometry
//   idx_width()   : channel index width, $clog2(n) with a floor of 1
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    MEM_RD,
    PER,
    RESP
  } mmio_state_t;

  localparam int unsigned MMIO_BASE_DEF = 1021;
  localparam int unsigned N_PERIPH_DEF  = 3;
  localparam int unsigned PERIPH_W_DEF  = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_timeout_cnt.sv
// mmio_timeout_cnt: peripheral acknowledge timeout counter.
// Only instantiated when PERIPH_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : synchronous clear (held while not waiting on a peripheral)
//   i_enable    : count one waiting cycle
//   o_expired   : count has reached TIMEOUT_CYC-1
module mmio_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: MEM-stage data bus controller. Routes each CPU data access
// either to the synchronous data RAM (mem0) or to one of N_PERIPH
// memory-mapped peripheral channels at word addresses MMIO_BASE+i, runs a
// req/ack handshake with the peripheral and stalls the pipeline until done.
// Optional feature macro: PERIPH_TIMEOUT_EN (peripheral ack timeout -> d_err).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   d_req/d_rw/daddr_in/ddata_w: CPU request, direction, address, write data
//   ddata_r/d_done/d_err       : response data, completion pulse, error flag
//   d_stall                    : pipeline stall (d_req & ~d_done)
//   mem0_en/rw/addr/dw, mem0_dr: data RAM strobe, controls and read data
//   per_req/per_rw/per_dout    : one-hot peripheral request, direction, data
//   per_din/per_ack            : packed peripheral read data, acknowledges
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PERIPH_W    = PERIPH_W_DEF,
  parameter int unsigned N_PERIPH    = N_PERIPH_DEF,
  parameter int unsigned MMIO_BASE   = MMIO_BASE_DEF,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         d_req,
  input  logic                         d_rw,
  input  logic [ADDR_W-1:0]            daddr_in,
  input  logic [DATA_W-1:0]            ddata_w,
  output logic [DATA_W-1:0]            ddata_r,
  output logic                         d_done,
  output logic                         d_stall,
  output logic                         d_err,
  output logic                         mem0_en,
  output logic                         mem0_rw,
  output logic [ADDR_W-1:0]            mem0_addr,
  output logic [DATA_W-1:0]            mem0_dw,
  input  logic [DATA_W-1:0]            mem0_dr,
  output logic [N_PERIPH-1:0]          per_req,
  output logic                         per_rw,
  output logic [PERIPH_W-1:0]          per_dout,
  input  logic [N_PERIPH*PERIPH_W-1:0] per_din,
  input  logic [N_PERIPH-1:0]          per_ack
);

  localparam int unsigned IDX_W = idx_width(N_PERIPH);

  mmio_state_t        r_state;
  logic               r_rw;
  logic [IDX_W-1:0]   r_idx;

  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_ack;
  logic               w_expired;
  logic [DATA_W-1:0]  w_per_rdata;

  assign w_hit = (daddr_in >= ADDR_W'(MMIO_BASE)) &&
                 (daddr_in <  ADDR_W'(MMIO_BASE + N_PERIPH));
  assign w_idx = IDX_W'(daddr_in - ADDR_W'(MMIO_BASE));

  // per_req is one-hot on the active channel, so masking with it ignores
  // acknowledges from every other channel.
  assign w_ack = |(per_ack & per_req);

  assign d_stall = d_req & ~d_done;

  always_comb begin
    w_per_rdata = '0;
    for (int unsigned i = 0; i < N_PERIPH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_per_rdata = DATA_W'(per_din[i*PERIPH_W +: PERIPH_W]);
      end
    end
  end

`ifdef PERIPH_TIMEOUT_EN
  logic w_tmo_clr;
  logic w_tmo_en;

  assign w_tmo_clr = (r_state != PER);
  assign w_tmo_en  = (r_state == PER) && !w_ack;

  mmio_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_tmo_clr),
    .i_enable (w_tmo_en),
    .o_expired(w_expired)
  );
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYC != 0);
  assign w_expired        = 1'b0;
`endif

  // Outputs are loaded on the transition into the state that drives them,
  // so each strobe is registered and aligned with that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rw      <= 1'b0;
      r_idx     <= '0;
      ddata_r   <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      mem0_en   <= 1'b0;
      mem0_rw   <= 1'b0;
      mem0_addr <= '0;
      mem0_dw   <= '0;
      per_req   <= '0;
      per_rw    <= 1'b0;
      per_dout  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (d_req) begin
            r_rw <= d_rw;
            if (w_hit) begin
              r_idx    <= w_idx;
              per_req  <= N_PERIPH'(1) << w_idx;
              per_rw   <= d_rw;
              per_dout <= ddata_w[PERIPH_W-1:0];
              r_state  <= PER;
            end else begin
              mem0_en   <= 1'b1;
              mem0_rw   <= d_rw;
              mem0_addr <= daddr_in;
              mem0_dw   <= ddata_w;
              r_state   <= MEM;
            end
          end
        end
        MEM: begin
          mem0_en   <= 1'b0;
          mem0_rw   <= 1'b0;
          mem0_addr <= '0;
          mem0_dw   <= '0;
          if (r_rw) begin
            d_done  <= 1'b1;
            r_state <= RESP;
          end else begin
            r_state <= MEM_RD;
          end
        end
        MEM_RD: begin
          ddata_r <= mem0_dr;
          d_done  <= 1'b1;
          r_state <= RESP;
        end
        PER: begin
          if (w_ack || w_expired) begin
            per_req  <= '0;
            per_rw   <= 1'b0;
            per_dout <= '0;
            d_done   <= 1'b1;
            r_state  <= RESP;
            // an ack on the timeout cycle takes priority over the error
            if (w_ack) begin
              ddata_r <= r_rw ? '0 : w_per_rdata;
            end else begin
              d_err <= 1'b1;
            end
          end
        end
        RESP: begin
          d_done  <= 1'b0;
          d_err   <= 1'b0;
          ddata_r <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl: directed self-checking bench for mmio_bus_ctrl.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
// Cycle 0 of a transaction is the cycle d_req is first presented in IDLE.
module tb_mmio_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        d_req;
  logic        d_rw;
  logic [31:0] daddr_in;
  logic [31:0] ddata_w;
  logic [31:0] ddata_r;
  logic        d_done;
  logic        d_stall;
  logic        d_err;
  logic        mem0_en;
  logic        mem0_rw;
  logic [31:0] mem0_addr;
  logic [31:0] mem0_dw;
  logic [31:0] mem0_dr;
  logic [2:0]  per_req;
  logic        per_rw;
  logic [15:0] per_dout;
  logic [47:0] per_din;
  logic [2:0]  per_ack;

  int n_chk  = 0;
  int n_fail = 0;

  mmio_bus_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .PERIPH_W   (16),
    .N_PERIPH   (3),
    .MMIO_BASE  (1021),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_req    (d_req),
    .d_rw     (d_rw),
    .daddr_in (daddr_in),
    .ddata_w  (ddata_w),
    .ddata_r  (ddata_r),
    .d_done   (d_done),
    .d_stall  (d_stall),
    .d_err    (d_err),
    .mem0_en  (mem0_en),
    .mem0_rw  (mem0_rw),
    .mem0_addr(mem0_addr),
    .mem0_dw  (mem0_dw),
    .mem0_dr  (mem0_dr),
    .per_req  (per_req),
    .per_rw   (per_rw),
    .per_dout (per_dout),
    .per_din  (per_din),
    .per_ack  (per_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ddata_r"}, 64'(ddata_r), 64'h0);
    chk({tag, ".d_done"}, 64'(d_done), 64'h0);
    chk({tag, ".d_stall"}, 64'(d_stall), 64'h0);
    chk({tag, ".d_err"}, 64'(d_err), 64'h0);
    chk({tag, ".mem0"}, {mem0_en, mem0_rw, mem0_addr, 30'h0}, 64'h0);
    chk({tag, ".mem0_dw"}, 64'(mem0_dw), 64'h0);
    chk({tag, ".per"}, {per_req, per_rw, per_dout}, 64'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    d_req    = 1'b0;
    d_rw     = 1'b0;
    daddr_in = '0;
    ddata_w  = '0;
    mem0_dr  = '0;
    per_din  = {16'h1111, 16'hA5A5, 16'h2222};
    per_ack  = '0;

    // reset held, then released with d_req=0
    tick(); tick();
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    tick();
    chk_all_zero("rst_rel");
    tick();
    chk_all_zero("idle");

    // RAM read, addr 100
    daddr_in = 32'd100; d_rw = 1'b0; d_req = 1'b1; mem0_dr = 32'h0BADF00D;
    #1;
    chk("rd.c0.stall", 64'(d_stall), 64'h1);
    chk("rd.c0.en", 64'(mem0_en), 64'h0);
    tick(); // c1
    chk("rd.c1.en_rw", {mem0_en, mem0_rw}, 64'h2);
    chk("rd.c1.addr", 64'(mem0_addr), 64'd100);
    chk("rd.c1.stall", 64'(d_stall), 64'h1);
    chk("rd.c1.done", 64'(d_done), 64'h0);
    tick(); // c2
    mem0_dr = 32'hDEADBEEF;
    chk("rd.c2.en", 64'(mem0_en), 64'h0);
    chk("rd.c2.stall_done", {d_stall, d_done}, 64'h2);
    tick(); // c3
    chk("rd.c3.done", 64'(d_done), 64'h1);
    chk("rd.c3.data", 64'(ddata_r), 64'hDEADBEEF);
    chk("rd.c3.stall_err", {d_stall, d_err}, 64'h0);
    d_req = 1'b0; mem0_dr = '0;
    tick(); // c4
    chk("rd.c4.done_data", {d_done, ddata_r}, 64'h0);

    // RAM write, addr 200, then back-to-back RAM read at addr 300
    daddr_in = 32'd200; d_rw = 1'b1; ddata_w = 32'h12345678; d_req = 1'b1;
    tick(); // c1
    chk("wr.c1.en_rw", {mem0_en, mem0_rw}, 64'h3);
    chk("wr.c1.dw", 64'(mem0_dw), 64'h12345678);
    chk("wr.c1.addr", 64'(mem0_addr), 64'd200);
    chk("wr.c1.per_req", 64'(per_req), 64'h0);
    tick(); // c2
    chk("wr.c2.done", 64'(d_done), 64'h1);
    chk("wr.c2.data", 64'(ddata_r), 64'h0);
    chk("wr.c2.en_stall", {mem0_en, d_stall}, 64'h0);
    chk("wr.c2.per_req", 64'(per_req), 64'h0);
    daddr_in = 32'd300; d_rw = 1'b0;
    tick(); // c3: IDLE, accepts next request
    chk("b2b.c3.done_en", {d_done, mem0_en}, 64'h0);
    chk("b2b.c3.stall", 64'(d_stall), 64'h1);
    tick(); // c4
    chk("b2b.c4.en_rw", {mem0_en, mem0_rw}, 64'h2);
    chk("b2b.c4.addr", 64'(mem0_addr), 64'd300);
    tick(); // c5
    mem0_dr = 32'h55AA55AA;
    tick(); // c6
    chk("b2b.c6.done", 64'(d_done), 64'h1);
    chk("b2b.c6.data", 64'(ddata_r), 64'h55AA55AA);
    d_req = 1'b0; mem0_dr = '0;
    tick();

    // peripheral read ch1 (addr 1022), d_req dropped mid-way, stray ack[0]
    daddr_in = 32'd1022; d_rw = 1'b0; d_req = 1'b1;
    tick(); // c1
    chk("pr.c1.per_req", 64'(per_req), 64'h2);
    chk("pr.c1.rw_en", {per_rw, mem0_en}, 64'h0);
    chk("pr.c1.stall", 64'(d_stall), 64'h1);
    tick(); // c2
    d_req = 1'b0; per_ack = 3'b001;
    #1;
    chk("pr.c2.stall_dropped", 64'(d_stall), 64'h0);
    tick(); // c3
    per_ack = 3'b000;
    chk("pr.c3.per_req", 64'(per_req), 64'h2);
    chk("pr.c3.done", 64'(d_done), 64'h0);
    tick(); // c4
    chk("pr.c4.per_req", 64'(per_req), 64'h2);
    per_ack = 3'b010;
    tick(); // c5
    per_ack = 3'b000;
    chk("pr.c5.done", 64'(d_done), 64'h1);
    chk("pr.c5.data", 64'(ddata_r), 64'h0000A5A5);
    chk("pr.c5.per_req", 64'(per_req), 64'h0);
    chk("pr.c5.err", 64'(d_err), 64'h0);
    tick(); // c6
    chk("pr.c6.done_data", {d_done, ddata_r}, 64'h0);

    // peripheral write ch2 (addr 1023), ack already high
    daddr_in = 32'd1023; d_rw = 1'b1; ddata_w = 32'hCAFEBEEF; per_ack = 3'b100; d_req = 1'b1;
    tick(); // c1
    chk("pw.c1.per_req", 64'(per_req), 64'h4);
    chk("pw.c1.per_rw", 64'(per_rw), 64'h1);
    chk("pw.c1.per_dout", 64'(per_dout), 64'hBEEF);
    chk("pw.c1.done", 64'(d_done), 64'h0);
    tick(); // c2
    chk("pw.c2.done", 64'(d_done), 64'h1);
    chk("pw.c2.data", 64'(ddata_r), 64'h0);
    chk("pw.c2.per", {per_req, per_rw, per_dout}, 64'h0);
    d_req = 1'b0; per_ack = '0;
    tick();

    // window boundaries: 1020 and 1024 go to RAM
    for (int i = 0; i < 2; i++) begin
      daddr_in = (i == 0) ? 32'd1020 : 32'd1024; d_rw = 1'b1; ddata_w = 32'h1; d_req = 1'b1;
      tick();
      chk("bnd.c1.mem0_en", 64'(mem0_en), 64'h1);
      chk("bnd.c1.per_req", 64'(per_req), 64'h0);
      tick();
      chk("bnd.c2.done", 64'(d_done), 64'h1);
      d_req = 1'b0;
      tick();
    end

    // lowest channel (addr 1021), ack in cycle 1
    daddr_in = 32'd1021; d_rw = 1'b0; d_req = 1'b1;
    tick(); // c1
    chk("ch0.c1.per_req", 64'(per_req), 64'h1);
    per_ack = 3'b001;
    tick(); // c2
    chk("ch0.c2.done", 64'(d_done), 64'h1);
    chk("ch0.c2.data", 64'(ddata_r), 64'h00002222);
    d_req = 1'b0; per_ack = '0;
    tick();

`ifdef PERIPH_TIMEOUT_EN
    // no ack: per_req held for 16 cycles, then error response
    daddr_in = 32'd1021; d_rw = 1'b0; d_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to.wait.per_req_done", {per_req, d_done}, 64'h2);
    end
    tick(); // c17
    chk("to.c17.done_err", {d_done, d_err}, 64'h3);
    chk("to.c17.data", 64'(ddata_r), 64'h0);
    chk("to.c17.per_req", 64'(per_req), 64'h0);
    d_req = 1'b0;
    tick();
    chk("to.c18.done_err", {d_done, d_err}, 64'h0);

    // ack on the 16th PER cycle wins
    daddr_in = 32'd1021; d_rw = 1'b0; d_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("toa.wait.per_req_done", {per_req, d_done}, 64'h2);
    end
    per_ack = 3'b001;
    tick(); // c17
    chk("toa.c17.done_err", {d_done, d_err}, 64'h2);
    chk("toa.c17.data", 64'(ddata_r), 64'h00002222);
    d_req = 1'b0; per_ack = '0;
    tick();
`else
    // no timeout: a long wait keeps the request up, late ack has no error
    daddr_in = 32'd1021; d_rw = 1'b0; d_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("nto.wait.per_req_done", {per_req, d_done}, 64'h2);
    end
    per_ack = 3'b001;
    tick();
    chk("nto.done_err", {d_done, d_err}, 64'h2);
    chk("nto.data", 64'(ddata_r), 64'h00002222);
    d_req = 1'b0; per_ack = '0;
    tick();
`endif

    // asynchronous reset while in PER
    daddr_in = 32'd1022; d_rw = 1'b0; d_req = 1'b1;
    tick(); // c1
    chk("arst.c1.per_req", 64'(per_req), 64'h2);
    tick(); // c2
    rst_n = 1'b0;
    #1;
    chk("arst.per_req_drop", 64'(per_req), 64'h0);
    d_req = 1'b0;
    tick();
    chk("arst.held.done", 64'(d_done), 64'h0);
    rst_n = 1'b1;
    tick();
    chk_all_zero("arst.rel");
    tick();
    chk("arst.after.done", 64'(d_done), 64'h0);

    // asynchronous reset while in MEM
    daddr_in = 32'd100; d_rw = 1'b0; d_req = 1'b1;
    tick(); // c1
    chk("arst_mem.c1.en", 64'(mem0_en), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem.en_drop", 64'(mem0_en), 64'h0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("arst_mem.after.done", 64'(d_done), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
Name: mmio_bus_ctrl

Overview:
- Parametrised, sequential data-side bus controller between the pipeline's MEM stage and the memory subsystem.
- Decodes each CPU data access to either the synchronous data RAM (mem0) or one of N_PERIPH memory-mapped peripheral channels.
- Runs a per-channel req/ack handshake and stalls the pipeline until the access completes.
- Replaces the fixed three-address combinational decode with a configurable window, a multi-cycle handshake and an error response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, CPU/RAM data width
PERIPH_W, 16, peripheral data width (PERIPH_W <= DATA_W)
N_PERIPH, 3, number of peripheral channels (1..8)
MMIO_BASE, 1021, word address of channel 0; channel i at MMIO_BASE+i
TIMEOUT_CYC, 16, peripheral ack timeout in cycles (used only with PERIPH_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_req  in  1  CPU access request, held until d_done
d_rw  in  1  1=write, 0=read
daddr_in  in  ADDR_W  CPU address
ddata_w  in  DATA_W  CPU write data
ddata_r  out  DATA_W  read data, valid while d_done=1
d_done  out  1  one-cycle completion pulse
d_stall  out  1  pipeline stall
d_err  out  1  error flag, valid while d_done=1
mem0_en  out  1  RAM access strobe
mem0_rw  out  1  RAM write enable (1=write)
mem0_addr  out  ADDR_W  RAM address
mem0_dw  out  DATA_W  RAM write data
mem0_dr  in  DATA_W  RAM read data, one cycle after mem0_en
per_req  out  N_PERIPH  one-hot peripheral request
per_rw  out  1  peripheral write enable
per_dout  out  PERIPH_W  peripheral write data, ddata_w[PERIPH_W-1:0]
per_din  in  N_PERIPH*PERIPH_W  peripheral read data; channel i at slice [i*PERIPH_W +: PERIPH_W]
per_ack  in  N_PERIPH  peripheral acknowledge

Behaviour:
- Reset: state=IDLE; all outputs 0 (ddata_r, d_done, d_stall, d_err, mem0_*, per_req, per_rw, per_dout); address/data/channel/counter registers cleared.
- States: IDLE, MEM, MEM_RD, PER, RESP.
- IDLE with d_req=1:
  - register addr, wdata, rw.
  - If MMIO_BASE <= addr < MMIO_BASE+N_PERIPH: register idx = addr-MMIO_BASE and go to PER.
  - Otherwise go to MEM.
- MEM:
  - mem0_en=1, mem0_rw=rw_q, mem0_addr=addr_q, mem0_dw=wdata_q, for exactly one cycle.
  - Write goes to RESP; read goes to MEM_RD.
- MEM_RD: capture mem0_dr into rdata_q; go to RESP.
- PER:
  - per_req[idx]=1, per_rw=rw_q, per_dout=wdata_q[PERIPH_W-1:0].
  - On per_ack[idx]=1: capture the per_din slice zero-extended to DATA_W (reads only); go to RESP.
  - per_ack on any other channel is ignored.
- RESP:
  - d_done=1, ddata_r=rdata_q (0 on writes), d_err=err_q; go to IDLE.
  - ddata_r and d_err are held at 0 outside RESP.
- d_stall = d_req & ~d_done. Combinational: high in the same cycle d_req rises.
- Latency (request accepted at cycle 0; d_done cycle):
  - RAM write: 2.
  - RAM read: 3.
  - Peripheral: ack at cycle k>=1 gives d_done at k+1.
- Back-to-back: a new request is accepted in IDLE the cycle after RESP. Minimum one idle cycle between transactions.
- d_req dropped mid-transaction: the transaction completes normally; the d_done pulse is still generated.
- per_ack already high on entering PER: the access completes with 1-cycle handshake (d_done at cycle 2).
- Address arithmetic is unsigned, ADDR_W bits. MMIO_BASE+N_PERIPH must not wrap.
- Asynchronous reset mid-transaction: per_req and mem0_en drop immediately; no d_done is produced.

Optional Feature:
PERIPH_TIMEOUT_EN
- Defined:
  - Cycle counter, cleared on entering PER, increments each PER cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 with no ack: drop per_req, set err_q, go to RESP. That response has ddata_r=0 and d_err=1.
  - An ack arriving on the timeout cycle wins, with no error.
- Undefined: PER waits indefinitely; d_err is constant 0.

Decomposition:
- Package mmio_pkg:
  - state enum type mmio_state_t {IDLE, MEM, MEM_RD, PER, RESP}.
  - Default constants MMIO_BASE_DEF=1021, N_PERIPH_DEF=3, PERIPH_W_DEF=16.
  - Function for channel index width, $clog2(N_PERIPH) with minimum 1.
- One sub-module: mmio_timeout_cnt (clear/enable/expired). Instantiated only under PERIPH_TIMEOUT_EN.

Test Plan:
- Reset held, then released with d_req=0: all outputs 0 and state IDLE. Assert rst_n=0 during PER: per_req drops asynchronously.
- RAM read, addr=100, mem0_dr=32'hDEADBEEF: mem0_en at cycle 1 with mem0_rw=0; d_done and ddata_r=32'hDEADBEEF at cycle 3; d_stall=1 for cycles 0-2.
- RAM write, addr=200, ddata_w=32'h12345678: mem0_en=1, mem0_rw=1, mem0_dw=32'h12345678 at cycle 1; d_done at cycle 2; per_req stays 0.
- Peripheral read, addr=1022, per_din slice1=16'hA5A5, ack at cycle 4: per_req=3'b010 for cycles 1-4; d_done at cycle 5 with ddata_r=32'h0000A5A5.
- Peripheral write, addr=1023, ack already high at cycle 1: per_req=3'b100, per_dout=ddata_w[15:0]; d_done at cycle 2. A stray per_ack[0] pulse is ignored.
- With PERIPH_TIMEOUT_EN and TIMEOUT_CYC=16, addr=1021, no ack: per_req drops after 16 cycles; d_done with d_err=1 and ddata_r=0. Repeat with ack on the 16th PER cycle: no error.
